// File: rtl/mul_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : mul_arbiter
// Purpose  : Shares one multiplier between two requesters, at most one op in
//            flight. Define MUL_ARB_RESULT_BUF_EN to add a result buffer.
// Revision : 1.0
// =============================================================================
module mul_arbiter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req0_valid_i,
  input  logic [63:0] req0_opr_a_i,
  input  logic [63:0] req0_opr_b_i,
  input  logic [3:0]  req0_func_i,
  input  logic        req0_word_i,
  output logic        req0_ready_o,
  input  logic        req1_valid_i,
  input  logic [63:0] req1_opr_a_i,
  input  logic [63:0] req1_opr_b_i,
  input  logic [3:0]  req1_func_i,
  input  logic        req1_word_i,
  output logic        req1_ready_o,
  output logic        res0_valid_o,
  output logic [63:0] res0_o,
  input  logic        res0_ready_i,
  output logic        res1_valid_o,
  output logic [63:0] res1_o,
  input  logic        res1_ready_i,
  output logic        mul_valid_o,
  output logic [63:0] opr_a_o,
  output logic [63:0] opr_b_o,
  output logic [3:0]  mul_func_o,
  output logic        word_op_o,
  input  logic        mul_ready_i,
  input  logic [63:0] mul_res_i,
  input  logic        mul_res_valid_i,
  output logic        mul_res_ready_o,
  output logic        mul_flush_o,
  input  logic        flush_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
`ifdef MUL_ARB_RESULT_BUF_EN
  localparam logic [1:0] S_HOLD = 2'd2;
`endif

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
`ifdef MUL_ARB_RESULT_BUF_EN
  logic        buf_valid_q, buf_valid_d;
  logic [63:0] buf_data_q, buf_data_d;
`endif

  logic        w_gnt_vld;
  logic        w_gnt_port;
  logic        w_issue;
  logic        w_owner_rdy;
  logic        w_res_vld;
  logic [63:0] w_res_data;

  // Grant is only offered while idle and out of reset, so outputs stay 0 in reset.
  always_comb begin
    w_gnt_vld  = 1'b0;
    w_gnt_port = 1'b0;
    if (resetn && state_q == S_IDLE) begin
      if (req0_valid_i && req1_valid_i) begin
        w_gnt_vld  = 1'b1;
        w_gnt_port = ~last_grant_q;
      end else if (req0_valid_i) begin
        w_gnt_vld  = 1'b1;
      end else if (req1_valid_i) begin
        w_gnt_vld  = 1'b1;
        w_gnt_port = 1'b1;
      end
    end
  end

  assign w_issue     = mul_valid_o & mul_ready_i;
  assign w_owner_rdy = owner_q ? res1_ready_i : res0_ready_i;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
`ifdef MUL_ARB_RESULT_BUF_EN
      buf_valid_q  <= 1'b0;
      buf_data_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
`ifdef MUL_ARB_RESULT_BUF_EN
      buf_valid_q  <= buf_valid_d;
      buf_data_q   <= buf_data_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
`ifdef MUL_ARB_RESULT_BUF_EN
    buf_valid_d  = buf_valid_q;
    buf_data_d   = buf_data_q;
`endif
    if (flush_i) begin
      // Flush abandons everything but deliberately leaves last_grant alone.
      state_d = S_IDLE;
`ifdef MUL_ARB_RESULT_BUF_EN
      buf_valid_d = 1'b0;
      buf_data_d  = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_issue) begin
            state_d      = S_BUSY;
            owner_d      = w_gnt_port;
            last_grant_d = w_gnt_port;
          end
        end
        S_BUSY: begin
`ifdef MUL_ARB_RESULT_BUF_EN
          if (mul_res_valid_i) begin
            state_d     = S_HOLD;
            buf_valid_d = 1'b1;
            buf_data_d  = mul_res_i;
          end
`else
          if (mul_res_valid_i && w_owner_rdy) state_d = S_IDLE;
`endif
        end
`ifdef MUL_ARB_RESULT_BUF_EN
        S_HOLD: begin
          if (w_owner_rdy) begin
            state_d     = S_IDLE;
            buf_valid_d = 1'b0;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mul_valid_o     = 1'b0;
    opr_a_o         = '0;
    opr_b_o         = '0;
    mul_func_o      = '0;
    word_op_o       = 1'b0;
    req0_ready_o    = 1'b0;
    req1_ready_o    = 1'b0;
    mul_res_ready_o = 1'b0;
    mul_flush_o     = 1'b0;
    w_res_vld       = 1'b0;
    w_res_data      = '0;
    if (resetn) begin
      mul_flush_o = flush_i;
      case (state_q)
        S_IDLE: begin
          if (w_gnt_vld) begin
            mul_valid_o  = ~flush_i;
            opr_a_o      = w_gnt_port ? req1_opr_a_i : req0_opr_a_i;
            opr_b_o      = w_gnt_port ? req1_opr_b_i : req0_opr_b_i;
            mul_func_o   = w_gnt_port ? req1_func_i  : req0_func_i;
            word_op_o    = w_gnt_port ? req1_word_i  : req0_word_i;
            req0_ready_o = ~w_gnt_port & mul_ready_i & ~flush_i;
            req1_ready_o =  w_gnt_port & mul_ready_i & ~flush_i;
          end
        end
        S_BUSY: begin
`ifdef MUL_ARB_RESULT_BUF_EN
          mul_res_ready_o = 1'b1;
`else
          w_res_vld       = mul_res_valid_i & ~flush_i;
          w_res_data      = mul_res_i;
          mul_res_ready_o = w_owner_rdy;
`endif
        end
`ifdef MUL_ARB_RESULT_BUF_EN
        S_HOLD: begin
          w_res_vld  = buf_valid_q & ~flush_i;
          w_res_data = buf_data_q;
        end
`endif
        default: ;
      endcase
    end
  end

  // Steer the result strictly to the owner; the other port sees all zeros.
  assign res0_valid_o = w_res_vld & ~owner_q;
  assign res1_valid_o = w_res_vld &  owner_q;
  assign res0_o       = owner_q ? '0 : w_res_data;
  assign res1_o       = owner_q ? w_res_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_mul_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_mul_arbiter
// Purpose  : Self-checking bench for mul_arbiter: vector table, directed corner
//            sequences and random traffic against a transaction-level model.
// Revision : 1.0
// =============================================================================
module tb_mul_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req0_valid_i, req1_valid_i;
  logic [63:0] req0_opr_a_i, req0_opr_b_i, req1_opr_a_i, req1_opr_b_i;
  logic [3:0]  req0_func_i, req1_func_i;
  logic        req0_word_i, req1_word_i;
  logic        req0_ready_o, req1_ready_o;
  logic        res0_valid_o, res1_valid_o;
  logic [63:0] res0_o, res1_o;
  logic        res0_ready_i, res1_ready_i;
  logic        mul_valid_o;
  logic [63:0] opr_a_o, opr_b_o;
  logic [3:0]  mul_func_o;
  logic        word_op_o;
  logic        mul_ready_i;
  logic [63:0] mul_res_i;
  logic        mul_res_valid_i;
  logic        mul_res_ready_o;
  logic        mul_flush_o;
  logic        flush_i;

  always #5 clk = ~clk;

  mul_arbiter dut (
    .clk(clk), .resetn(resetn),
    .req0_valid_i(req0_valid_i), .req0_opr_a_i(req0_opr_a_i), .req0_opr_b_i(req0_opr_b_i),
    .req0_func_i(req0_func_i), .req0_word_i(req0_word_i), .req0_ready_o(req0_ready_o),
    .req1_valid_i(req1_valid_i), .req1_opr_a_i(req1_opr_a_i), .req1_opr_b_i(req1_opr_b_i),
    .req1_func_i(req1_func_i), .req1_word_i(req1_word_i), .req1_ready_o(req1_ready_o),
    .res0_valid_o(res0_valid_o), .res0_o(res0_o), .res0_ready_i(res0_ready_i),
    .res1_valid_o(res1_valid_o), .res1_o(res1_o), .res1_ready_i(res1_ready_i),
    .mul_valid_o(mul_valid_o), .opr_a_o(opr_a_o), .opr_b_o(opr_b_o),
    .mul_func_o(mul_func_o), .word_op_o(word_op_o), .mul_ready_i(mul_ready_i),
    .mul_res_i(mul_res_i), .mul_res_valid_i(mul_res_valid_i),
    .mul_res_ready_o(mul_res_ready_o), .mul_flush_o(mul_flush_o), .flush_i(flush_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: which port owns the single outstanding op, whether its
  // result is parked in the buffer, and who won the last issue.
  bit          m_busy, m_held, m_owner, m_last;
  logic [63:0] m_buf;
  bit          n_busy, n_held, n_owner, n_last;
  logic [63:0] n_buf;
  // Multiplier stand-in: one pending product, presented until accepted.
  bit          mp_pend, np_pend;
  logic [63:0] mp_val, np_val;

  typedef struct {
    logic        v0, v1, fl, mr;
    logic        mv;
    logic [63:0] a;
    logic        r0, r1;
  } vec_t;
  vec_t tbl[7];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] product(input logic [63:0] a, input logic [63:0] b,
                                          input logic word);
    logic [31:0] lo;
    lo = a[31:0] * b[31:0];
    return word ? {{32{lo[31]}}, lo} : a * b;
  endfunction

  task automatic quiet();
    req0_valid_i = 0; req1_valid_i = 0; flush_i = 0; mul_ready_i = 0;
    res0_ready_i = 0; res1_ready_i = 0; mul_res_valid_i = 0; mul_res_i = '0;
    req0_opr_a_i = 64'h1111; req0_opr_b_i = 64'h10; req0_func_i = 4'd0; req0_word_i = 0;
    req1_opr_a_i = 64'h2222; req1_opr_b_i = 64'h20; req1_func_i = 4'd3; req1_word_i = 0;
  endtask

  task automatic drive_res(input bit want);
    mul_res_valid_i = want && mp_pend;
    mul_res_i       = mul_res_valid_i ? mp_val : 64'hDEAD_0000_BEEF_0000;
  endtask

  // Compare every output against the model, then prepare the model's next view.
  task automatic check_cycle();
    logic [63:0] e_a, e_b, e_d0, e_d1;
    logic [3:0]  e_f;
    logic        e_w, e_mv, e_r0, e_r1, e_v0, e_v1, e_mrr, rr_own;
    int          g;
    #1;
    e_a = '0; e_b = '0; e_d0 = '0; e_d1 = '0; e_f = '0;
    e_w = 0; e_mv = 0; e_r0 = 0; e_r1 = 0; e_v0 = 0; e_v1 = 0; e_mrr = 0;
    g = -1;
    rr_own = m_owner ? res1_ready_i : res0_ready_i;
    if (!resetn) begin
      m_busy = 0; m_held = 0; m_owner = 0; m_last = 1; m_buf = '0; mp_pend = 0;
    end else if (!m_busy && !m_held) begin
      if (req0_valid_i && req1_valid_i) g = m_last ? 0 : 1;
      else if (req0_valid_i) g = 0;
      else if (req1_valid_i) g = 1;
      if (g == 0) begin e_a = req0_opr_a_i; e_b = req0_opr_b_i; e_f = req0_func_i; e_w = req0_word_i; end
      if (g == 1) begin e_a = req1_opr_a_i; e_b = req1_opr_b_i; e_f = req1_func_i; e_w = req1_word_i; end
      e_mv = (g >= 0) && !flush_i;
      e_r0 = (g == 0) && mul_ready_i && !flush_i;
      e_r1 = (g == 1) && mul_ready_i && !flush_i;
    end else if (m_busy) begin
`ifdef MUL_ARB_RESULT_BUF_EN
      e_mrr = 1;
`else
      e_mrr = rr_own;
      if (m_owner) begin e_v1 = mul_res_valid_i && !flush_i; e_d1 = mul_res_i; end
      else         begin e_v0 = mul_res_valid_i && !flush_i; e_d0 = mul_res_i; end
`endif
    end else begin
      if (m_owner) begin e_v1 = !flush_i; e_d1 = m_buf; end
      else         begin e_v0 = !flush_i; e_d0 = m_buf; end
    end
    chk1 ("mul_valid_o", mul_valid_o, e_mv);
    chk64("opr_a_o", opr_a_o, e_a);
    chk64("opr_b_o", opr_b_o, e_b);
    chk64("mul_func_o", {60'd0, mul_func_o}, {60'd0, e_f});
    chk1 ("word_op_o", word_op_o, e_w);
    chk1 ("req0_ready_o", req0_ready_o, e_r0);
    chk1 ("req1_ready_o", req1_ready_o, e_r1);
    chk1 ("res0_valid_o", res0_valid_o, e_v0);
    chk1 ("res1_valid_o", res1_valid_o, e_v1);
    chk64("res0_o", res0_o, e_d0);
    chk64("res1_o", res1_o, e_d1);
    chk1 ("mul_res_ready_o", mul_res_ready_o, e_mrr);
    chk1 ("mul_flush_o", mul_flush_o, resetn && flush_i);

    n_busy = m_busy; n_held = m_held; n_owner = m_owner; n_last = m_last; n_buf = m_buf;
    np_pend = mp_pend; np_val = mp_val;
    if (resetn) begin
      if (flush_i) begin
        n_busy = 0; n_held = 0; n_buf = '0; np_pend = 0;
      end else if (!m_busy && !m_held) begin
        if (e_mv && mul_ready_i) begin
          n_busy = 1; n_owner = g[0]; n_last = g[0]; np_pend = 1;
          np_val = product(e_a, e_b, e_w);
        end
      end else if (m_busy) begin
        if (mul_res_valid_i && e_mrr) np_pend = 0;
`ifdef MUL_ARB_RESULT_BUF_EN
        if (mul_res_valid_i) begin n_busy = 0; n_held = 1; n_buf = mul_res_i; end
`else
        if (mul_res_valid_i && rr_own) n_busy = 0;
`endif
      end else if (rr_own) begin
        n_held = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_busy = n_busy; m_held = n_held; m_owner = n_owner; m_last = n_last; m_buf = n_buf;
    mp_pend = np_pend; mp_val = np_val;
  endtask

  task automatic do_reset();
    quiet();
    resetn = 0;
    check_cycle();
    tick();
    resetn = 1;
  endtask

  initial begin
    int          grants[$];
    int          pulses;
    bit          seen;
    logic [63:0] held_val;

    tbl[0] = '{v0:0, v1:0, fl:0, mr:1, mv:0, a:64'h0,    r0:0, r1:0};
    tbl[1] = '{v0:1, v1:0, fl:0, mr:1, mv:1, a:64'h1111, r0:1, r1:0};
    tbl[2] = '{v0:0, v1:1, fl:0, mr:1, mv:1, a:64'h2222, r0:0, r1:1};
    tbl[3] = '{v0:1, v1:1, fl:0, mr:1, mv:1, a:64'h1111, r0:1, r1:0};
    tbl[4] = '{v0:1, v1:1, fl:1, mr:1, mv:0, a:64'h1111, r0:0, r1:0};
    tbl[5] = '{v0:1, v1:1, fl:0, mr:0, mv:1, a:64'h1111, r0:0, r1:0};
    tbl[6] = '{v0:0, v1:1, fl:1, mr:0, mv:0, a:64'h2222, r0:0, r1:0};

    // Reset with busy-looking inputs: every output must read 0.
    quiet();
    resetn = 0;
    req0_valid_i = 1; req1_valid_i = 1; flush_i = 1; mul_ready_i = 1;
    res0_ready_i = 1; res1_ready_i = 1;
    check_cycle();
    tick();
    check_cycle();
    tick();
    resetn = 1;
    quiet();

    // Idle-state grant table: inputs withdrawn before the edge so nothing issues.
    for (int i = 0; i < 7; i++) begin
      req0_valid_i = tbl[i].v0; req1_valid_i = tbl[i].v1;
      flush_i = tbl[i].fl; mul_ready_i = tbl[i].mr;
      #1;
      chk1 ($sformatf("tbl%0d_mul_valid", i), mul_valid_o, tbl[i].mv);
      chk64($sformatf("tbl%0d_opr_a", i), opr_a_o, tbl[i].a);
      chk1 ($sformatf("tbl%0d_ready0", i), req0_ready_o, tbl[i].r0);
      chk1 ($sformatf("tbl%0d_ready1", i), req1_ready_o, tbl[i].r1);
      chk1 ($sformatf("tbl%0d_flush", i), mul_flush_o, tbl[i].fl);
      quiet();
      check_cycle();
      tick();
    end

    // Port 0 alone: 3 * 5.
    quiet();
    req0_valid_i = 1; req0_opr_a_i = 64'd3; req0_opr_b_i = 64'd5; res0_ready_i = 1; mul_ready_i = 1;
    check_cycle();
    chk1 ("mul3x5_issue", mul_valid_o, 1'b1);
    chk64("mul3x5_opr_a", opr_a_o, 64'd3);
    tick();
    seen = 0;
    for (int c = 0; c < 4 && !seen; c++) begin
      quiet(); res0_ready_i = 1; drive_res(1);
      check_cycle();
      if (res0_valid_o) begin
        seen = 1;
        chk64("mul3x5_res0", res0_o, 64'd15);
      end
      chk1("mul3x5_res1_quiet", res1_valid_o, 1'b0);
      tick();
    end
    chk1("mul3x5_delivered", seen, 1'b1);

    // Contention from reset: grants alternate 0,1,0,1.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      req0_valid_i = 1; req1_valid_i = 1; mul_ready_i = 1;
      res0_ready_i = 1; res1_ready_i = 1; drive_res(1);
      check_cycle();
      if (req0_ready_o) grants.push_back(0);
      if (req1_ready_o) grants.push_back(1);
      tick();
    end
    chk1("alt_count", grants.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++)
      chk64($sformatf("alt_grant%0d", i), 64'(i < grants.size() ? grants[i] : 9), 64'(i % 2));

    // Port 1 result stalled by its requester for several cycles.
    do_reset();
    req1_valid_i = 1; mul_ready_i = 1;
    check_cycle();
    chk1("stall_issue1", req1_ready_o, 1'b1);
    tick();
    pulses = 0; seen = 0; held_val = '0;
    for (int c = 0; c < 6; c++) begin
      quiet(); req0_valid_i = 1; mul_ready_i = 1; drive_res(1);
      check_cycle();
      if (mul_res_ready_o) pulses++;
      chk1($sformatf("stall_nogrant%0d", c), req0_ready_o, 1'b0);
      if (res1_valid_o && !seen) begin seen = 1; held_val = res1_o; end
      else if (seen) chk64($sformatf("stall_stable%0d", c), res1_o, held_val);
      tick();
    end
`ifdef MUL_ARB_RESULT_BUF_EN
    chk64("stall_res_ready_pulses", 64'(pulses), 64'd1);
`else
    chk64("stall_res_ready_pulses", 64'(pulses), 64'd0);
`endif
    quiet(); res1_ready_i = 1; drive_res(1);
    check_cycle();
    chk1("stall_release", res1_valid_o, 1'b1);
    tick();

    // Flush: idle contention, then on the result cycle.
    do_reset();
    req0_valid_i = 1; req1_valid_i = 1; mul_ready_i = 1; flush_i = 1;
    check_cycle();
    chk1("flush_idle_no_issue", mul_valid_o, 1'b0);
    tick();
    flush_i = 0;
    check_cycle();
    chk1("flush_same_winner", req0_ready_o, 1'b1);
    tick();
    quiet(); res0_ready_i = 1; flush_i = 1; drive_res(1);
    check_cycle();
    chk1("flush_res0_killed", res0_valid_o, 1'b0);
    chk1("flush_pass", mul_flush_o, 1'b1);
    tick();
    quiet(); req0_valid_i = 1; req1_valid_i = 1; mul_ready_i = 1;
    check_cycle();
    chk1("flush_idle_next", req1_ready_o, 1'b1);
    tick();

    // Asynchronous reset while busy (owner is port 1 here).
    quiet(); req0_valid_i = 1; req1_valid_i = 1; res1_ready_i = 1; drive_res(1);
    #2;
    resetn = 0;
    check_cycle();
    chk1("rst_busy_res1", res1_valid_o, 1'b0);
    chk1("rst_busy_mrr", mul_res_ready_o, 1'b0);
    tick();
    resetn = 1;
    quiet(); req0_valid_i = 1; req1_valid_i = 1; mul_ready_i = 1;
    check_cycle();
    chk1("rst_port0_wins", req0_ready_o, 1'b1);
    tick();

    // Word op forwarded; result passed through unmodified.
    do_reset();
    req0_valid_i = 1; req0_opr_a_i = 64'hFFFF_FFFF; req0_opr_b_i = 64'd2; req0_word_i = 1;
    mul_ready_i = 1;
    check_cycle();
    chk1("word_fwd", word_op_o, 1'b1);
    tick();
    seen = 0;
    for (int c = 0; c < 4 && !seen; c++) begin
      quiet(); res0_ready_i = 1; drive_res(1);
      check_cycle();
      if (res0_valid_o) begin
        seen = 1;
        chk64("word_res0", res0_o, 64'hFFFF_FFFF_FFFF_FFFE);
      end
      tick();
    end
    chk1("word_delivered", seen, 1'b1);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      req0_valid_i = ($urandom % 3) != 0;
      req1_valid_i = ($urandom % 3) != 0;
      req0_opr_a_i = {$urandom, $urandom}; req0_opr_b_i = {$urandom, $urandom};
      req1_opr_a_i = {$urandom, $urandom}; req1_opr_b_i = {$urandom, $urandom};
      req0_func_i  = 4'($urandom % 4);     req1_func_i  = 4'($urandom % 4);
      req0_word_i  = ($urandom % 2) == 1;  req1_word_i  = ($urandom % 2) == 1;
      res0_ready_i = ($urandom % 4) != 0;  res1_ready_i = ($urandom % 4) != 0;
      mul_ready_i  = ($urandom % 4) != 0;
      flush_i      = ($urandom % 25) == 0;
      drive_res(($urandom % 2) == 1);
      check_cycle();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; resetn  in  1  asynchronous active-low reset.
REQ-002 SHALL have requester ports, for n in {0,1}: req{n}_valid_i  in  1  request valid; req{n}_opr_a_i  in  64  operand A; req{n}_opr_b_i  in  64  operand B; req{n}_func_i  in  4  multiply function (OP_MUL/OP_MULH/OP_MULHSU/OP_MULHU); req{n}_word_i  in  1  32-bit word op; req{n}_ready_o  out  1  request accepted.
REQ-003 SHALL have result ports, for n in {0,1}: res{n}_valid_o  out  1  result valid; res{n}_o  out  64  result; res{n}_ready_i  in  1  requester accepts result.
REQ-004 SHALL have multiplier-side ports: mul_valid_o  out  1; opr_a_o  out  64; opr_b_o  out  64; mul_func_o  out  4; word_op_o  out  1; mul_ready_i  in  1; mul_res_i  in  64; mul_res_valid_i  in  1; mul_res_ready_o  out  1; mul_flush_o  out  1.
REQ-005 SHALL have flush_i  in  1  pipeline flush that kills any in-flight or buffered operation.

Function
REQ-006 SHALL share one multiplier between two requesters, with at most one operation outstanding.
REQ-007 SHALL implement states S_IDLE (no op outstanding), S_BUSY (op issued, awaiting result) and S_HOLD (result buffered, awaiting requester; present only with the buffer feature).
REQ-008 In S_IDLE, the grant SHALL be combinational. If only one reqN_valid_i is high, that port wins. If both are high, the port not equal to last_grant wins.
REQ-009 In S_IDLE, mul_valid_o SHALL equal the granted port's valid gated by ~flush_i. opr_a_o, opr_b_o, mul_func_o and word_op_o SHALL mux from the granted port. They SHALL be zero when nothing is granted.
REQ-010 reqN_ready_o SHALL be high only for the granted port, in S_IDLE, when mul_ready_i=1 and flush_i=0. It SHALL be 0 in every other state.
REQ-011 An issue SHALL occur on mul_valid_o & mul_ready_i. On issue, owner <= granted port, last_grant <= granted port, and the state SHALL go to S_BUSY.
REQ-012 In S_BUSY without the buffer: res{owner}_valid_o = mul_res_valid_i & ~flush_i, res{owner}_o = mul_res_i, and mul_res_ready_o = res{owner}_ready_i. The other port's valid SHALL be 0 and its data zero.
REQ-013 A result handshake in S_BUSY (unbuffered) SHALL return the state to S_IDLE. The next issue SHALL be possible in the following cycle, giving one idle cycle between back-to-back ops.
REQ-014 flush_i SHALL be passed combinationally to mul_flush_o. flush_i high in any state SHALL force S_IDLE next cycle, clear any buffered result, and suppress every res{n}_valid_o and mul_valid_o in that cycle. last_grant SHALL be unchanged by a flush.
REQ-015 A new request arriving in the same cycle as a result handshake SHALL NOT be granted until S_IDLE is entered.
REQ-016 Results SHALL never be delivered to the non-owner port, and SHALL never be dropped except on flush_i.

Reset
REQ-017 On resetn low, the block SHALL asynchronously reach S_IDLE with owner=0, last_grant=1 (port 0 wins the first contention), and buffer valid=0 and data=0.
REQ-018 During reset, all outputs SHALL be 0. Reset mid-operation SHALL discard the outstanding op without any result handshake.

Configuration
REQ-019 Macro MUL_ARB_RESULT_BUF_EN, when defined, SHALL add a 64-bit result register and state S_HOLD:
- In S_BUSY, mul_res_ready_o=1.
- On mul_res_valid_i, the result is captured and the state goes to S_HOLD.
- In S_HOLD, res{owner}_valid_o=1 and res{owner}_o=buffer, and mul_res_ready_o=0.
- On res{owner}_ready_i, the state goes to S_IDLE.
- The multiplier is freed the cycle its result appears, regardless of requester stall.
REQ-020 When MUL_ARB_RESULT_BUF_EN is undefined, the block SHALL have no buffer or S_HOLD, and results pass through per REQ-012.

Verification
REQ-021 Port 0 alone, a=3, b=5, OP_MUL, res0_ready_i=1 -> one issue with opr_a_o=3; res0_valid_o with res0_o=15; res1_valid_o stays 0.
REQ-022 Both ports valid every cycle after reset -> grants alternate 0,1,0,1. Each result is routed only to its issuer.
REQ-023 Port 1 issues, then res1_ready_i is held low for 5 cycles -> unbuffered: mul_res_ready_o low for 5 cycles, no new grant. Buffered: mul_res_ready_o pulses once, S_HOLD is held for 5 cycles, and res1_o is stable.
REQ-024 flush_i asserted in S_BUSY on the result cycle -> no res{n}_valid_o; mul_flush_o=1; S_IDLE next cycle; last_grant is unchanged, so the same contention winner repeats.
REQ-025 resetn deasserted then asserted low while in S_BUSY -> all outputs 0 immediately. After release, port 0 wins contention.
REQ-026 Word op, port 0, a=0xFFFFFFFF, b=2, word=1 -> word_op_o=1 is forwarded. res0_o equals the multiplier's mul_res_i (0xFFFFFFFFFFFFFFFE) unmodified.
